ls_stage_lsu: RTL and testbench
===============================

Name: ls_stage_lsu

Overview:
- Consumer end of the EX->LS pipeline register. Takes the registered PC, instruction, ALU result (effective address or ALU value), rs2 and write-back enable.
- Loads and stores run as single-beat transactions on a valid/ready request plus valid response memory port. Load data is lane-extracted and sign/zero-extended.
- A registered result goes to the LS->WB boundary. Non-memory instructions pass through with one cycle of latency.
- in_ready_o stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- XLEN, 64, data and address width.
- INST_LEN, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid_i  in  1  LS-stage inputs are valid this cycle.
- in_ready_o  out  1  block accepts inputs; equals (state==IDLE).
- pc_i  in  XLEN  instruction PC.
- instr_i  in  INST_LEN  instruction; opcode is [6:0], funct3 is [14:12].
- alures_i  in  XLEN  effective address, or ALU result for non-memory instructions.
- rs2_i  in  XLEN  store data.
- wben_i  in  1  register write-back enable.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_addr_o  out  XLEN  address with bits [2:0] forced to 0.
- mem_wen_o  out  1  1=store, 0=load.
- mem_wdata_o  out  XLEN  store data shifted into its byte lanes.
- mem_wmask_o  out  XLEN/8  byte-lane write mask; 0 for loads.
- mem_rsp_valid_i  in  1  response valid (load data, or store ack).
- mem_rdata_i  in  XLEN  aligned 64-bit read data.
- wb_valid_o  out  1  one-cycle pulse: WB outputs are valid.
- wb_pc_o  out  XLEN  PC of the completed instruction.
- wb_instr_o  out  INST_LEN  completed instruction.
- wb_data_o  out  XLEN  load result or pass-through ALU result.
- wb_wben_o  out  1  write-back enable.
- misalign_o  out  1  accompanies wb_valid_o; the access was misaligned.

Behaviour:
- Reset (asynchronous, rstn=0):
  - state goes to IDLE.
  - All outputs are 0 except in_ready_o, which is 1.
- Instruction classes:
  - opcode 0000011 is a load; funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - opcode 0100011 is a store; funct3 000 SB, 001 SH, 010 SW, 011 SD.
  - Any other opcode is pass-through.
  - Load funct3 111 and store funct3 1xx are treated as pass-through with wben forced to 0.
- Acceptance: inputs are captured on a clock edge where in_valid_i && in_ready_o. The captured inputs are held internally; upstream may change its inputs afterwards.
- States are IDLE, REQ and WAIT.
- IDLE:
  - Accepted pass-through: next cycle wb_valid_o=1 with wb_data_o=alures_i and wb_wben_o=wben_i. State stays IDLE, so back-to-back pass-through runs at 1 per cycle.
  - Accepted aligned load or store: go to REQ.
  - Accepted misaligned access: next cycle wb_valid_o=1, misalign_o=1, wb_wben_o=0, wb_data_o=0. No memory request is issued and state stays IDLE.
  - Misaligned means: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
- REQ:
  - mem_req_valid_o=1.
  - mem_addr_o, mem_wen_o, mem_wdata_o and mem_wmask_o are held stable until mem_req_ready_i.
  - On a cycle with mem_req_valid_o && mem_req_ready_i, go to WAIT.
- WAIT:
  - mem_req_valid_o=0.
  - mem_rsp_valid_i is sampled only in WAIT; any response outside WAIT is ignored.
  - On mem_rsp_valid_i, go to IDLE. On the next cycle wb_valid_o=1, misalign_o=0 and wb_wben_o=captured wben.
  - For a load, wb_data_o is the extended result. For a store, wb_data_o=0.
  - Minimum load/store latency is 3 cycles from accept to wb_valid_o, with zero-wait memory.
- Store lane formation, with off=addr[2:0]:
  - mem_wdata_o = rs2 << (8*off).
  - mem_wmask_o is the size mask shifted left by off: SB=0x01, SH=0x03, SW=0x0F, SD=0xFF.
- Load extraction:
  - raw = mem_rdata_i >> (8*off), truncated to the access size.
  - LB, LH and LW sign-extend to XLEN. LBU, LHU and LWU zero-extend. LD takes all 64 bits.
- WB output rules:
  - wb_valid_o is a single-cycle pulse.
  - wb_pc_o, wb_instr_o, wb_data_o, wb_wben_o and misalign_o hold their last values when wb_valid_o=0.
- Simultaneous events: in IDLE, completion output of the previous instruction and acceptance of a new instruction happen in the same cycle.
- Reset mid-operation (REQ or WAIT): return to IDLE immediately. The outstanding transaction is abandoned and no wb_valid_o is produced for it.

Test Plan:
- Pass-through: opcode 0110011, alures=0x1234, wben=1, three back-to-back -> wb_valid_o=1 on 3 consecutive cycles, wb_data_o=0x1234, in_ready_o stays 1.
- LB at 0x8000_0003, mem_rdata=0x0000_0000_8000_0000 (lane 3 = 0x80) -> mem_addr_o=0x8000_0000, mem_wmask_o=0, wb_data_o=0xFFFF_FFFF_FFFF_FF80. The same access as LBU -> 0x80.
- SH at 0x8000_0006, rs2=0xABCD_1234 -> mem_wmask_o=0xC0, mem_wdata_o=0x1234_0000_0000_0000, mem_wen_o=1; after the ack, wb_valid_o with wb_data_o=0.
- Backpressure: LD at 0x8000_0008, mem_req_ready_i low for 3 cycles -> req/addr held stable, in_ready_o=0 throughout; response 0x1122_3344_5566_7788 -> wb_data_o equals that value.
- Misaligned LW at 0x8000_0002 -> no mem_req_valid_o, next cycle wb_valid_o=1, misalign_o=1, wb_wben_o=0.
- Reset asserted in WAIT -> all outputs 0 and in_ready_o=1 immediately; a later mem_rsp_valid_i produces no wb_valid_o.

Source files
------------

// File: rtl/ls_stage_lsu.sv
// LS pipeline stage: load/store unit on a valid/ready memory port.
// Non-memory instructions pass straight through to the WB boundary.
module ls_stage_lsu #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic [XLEN-1:0]     alures_i,
    input  logic [XLEN-1:0]     rs2_i,
    input  logic                wben_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic                mem_wen_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN/8-1:0]   mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                wb_valid_o,
    output logic [XLEN-1:0]     wb_pc_o,
    output logic [INST_LEN-1:0] wb_instr_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic                wb_wben_o,
    output logic                misalign_o
);

    localparam int NB = XLEN / 8;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] instr;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     rs2;
        logic                wben;
        logic                ld;
        logic                st;
    } ls_req_t;

    state_t  state, state_n;
    ls_req_t cur;

    logic [6:0] op;
    logic [2:0] f3;
    logic       is_ld, is_st, bad, mis;

    assign op    = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign is_ld = (op == OP_LD) && (f3 != 3'b111);
    assign is_st = (op == OP_ST) && !f3[2];
    assign bad   = ((op == OP_LD) && (f3 == 3'b111))
                || ((op == OP_ST) && f3[2]);

    always_comb begin
        mis = 1'b0;
        unique case (f3[1:0])
            2'd0: mis = 1'b0;
            2'd1: mis = alures_i[0];
            2'd2: mis = |alures_i[1:0];
            2'd3: mis = |alures_i[2:0];
            default: mis = 1'b0;
        endcase
    end

    logic [2:0]      off;
    logic [2:0]      cf3;
    logic [NB-1:0]   smask;
    logic [XLEN-1:0] raw, ld_data;

    assign off = cur.addr[2:0];
    assign cf3 = cur.instr[14:12];

    always_comb begin
        smask = '0;
        unique case (cf3[1:0])
            2'd0: smask = NB'(8'h01);
            2'd1: smask = NB'(8'h03);
            2'd2: smask = NB'(8'h0F);
            2'd3: smask = NB'(8'hFF);
            default: smask = '0;
        endcase
    end

    assign in_ready_o      = (state == S_IDLE);
    assign mem_req_valid_o = (state == S_REQ);
    assign mem_addr_o      = {cur.addr[XLEN-1:3], 3'b000};
    assign mem_wen_o       = cur.st;
    assign mem_wdata_o     = cur.rs2 << {off, 3'b000};
    assign mem_wmask_o     = cur.st ? (smask << off) : '0;

    // Lane 0 of the shifted word holds the addressed element.
    assign raw = mem_rdata_i >> {off, 3'b000};

    always_comb begin
        ld_data = raw;
        unique case (cf3)
            3'b000: ld_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001: ld_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b010: ld_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101: ld_data = {{(XLEN-16){1'b0}}, raw[15:0]};
            3'b110: ld_data = {{(XLEN-32){1'b0}}, raw[31:0]};
            default: ld_data = raw;
        endcase
    end

    logic                take, fire;
    logic [XLEN-1:0]     wpc_n, wdata_n;
    logic [INST_LEN-1:0] winstr_n;
    logic                wwben_n, wmis_n;

    always_comb begin
        state_n  = state;
        take     = 1'b0;
        fire     = 1'b0;
        wpc_n    = cur.pc;
        winstr_n = cur.instr;
        wdata_n  = '0;
        wwben_n  = 1'b0;
        wmis_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid_i) begin
                    take     = 1'b1;
                    wpc_n    = pc_i;
                    winstr_n = instr_i;
                    if (is_ld || is_st) begin
                        if (mis) begin
                            fire   = 1'b1;
                            wmis_n = 1'b1;
                        end else begin
                            state_n = S_REQ;
                        end
                    end else begin
                        fire    = 1'b1;
                        wdata_n = alures_i;
                        wwben_n = wben_i & ~bad;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_n = S_IDLE;
                    fire    = 1'b1;
                    wdata_n = cur.ld ? ld_data : '0;
                    wwben_n = cur.wben;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cur   <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                cur.pc    <= pc_i;
                cur.instr <= instr_i;
                cur.addr  <= alures_i;
                cur.rs2   <= rs2_i;
                cur.wben  <= wben_i;
                cur.ld    <= is_ld && !mis;
                cur.st    <= is_st && !mis;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid_o <= 1'b0;
            wb_pc_o    <= '0;
            wb_instr_o <= '0;
            wb_data_o  <= '0;
            wb_wben_o  <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            wb_valid_o <= fire;
            if (fire) begin
                wb_pc_o    <= wpc_n;
                wb_instr_o <= winstr_n;
                wb_data_o  <= wdata_n;
                wb_wben_o  <= wwben_n;
                misalign_o <= wmis_n;
            end
        end
    end

endmodule

// File: tb/tb_ls_stage_lsu.sv
// Bench for ls_stage_lsu: directed vectors checked against a
// behavioural model queue plus literal expectations.
module tb_ls_stage_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid_i, in_ready_o;
    logic [63:0] pc_i, alures_i, rs2_i;
    logic [31:0] instr_i;
    logic        wben_i;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_wen_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_rsp_valid_i;
    logic        wb_valid_o;
    logic [63:0] wb_pc_o, wb_data_o;
    logic [31:0] wb_instr_o;
    logic        wb_wben_o, misalign_o;

    ls_stage_lsu #(.XLEN(64), .INST_LEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .alures_i(alures_i),
        .rs2_i(rs2_i), .wben_i(wben_i),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o),
        .wb_instr_o(wb_instr_o), .wb_data_o(wb_data_o),
        .wb_wben_o(wb_wben_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] data;
        logic        wben;
        logic        mis;
    } wb_t;

    wb_t expq[$];
    int  checks = 0;
    int  fails  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3);
        return {17'b0, f3, 5'b0, op};
    endfunction

    // What the WB boundary must show for one instruction.
    function automatic wb_t model(input logic [63:0] pc,
                                  input logic [31:0] instr,
                                  input logic [63:0] addr,
                                  input logic wben,
                                  input logic [63:0] rdata);
        wb_t r;
        int nb, off;
        logic [63:0] v, m;
        r.pc = pc; r.instr = instr; r.data = addr;
        r.wben = wben; r.mis = 1'b0;
        nb  = 1 << instr[13:12];
        off = int'(addr[2:0]);
        if (instr[6:0] == 7'h03) begin
            if (instr[14:12] == 3'd7) begin
                r.wben = 1'b0;
                return r;
            end
            if (off % nb != 0) begin
                r.data = 0; r.wben = 1'b0; r.mis = 1'b1;
                return r;
            end
            v = rdata >> (8 * off);
            if (nb < 8) begin
                m = (64'd1 << (8 * nb)) - 64'd1;
                v = v & m;
                if (!instr[14] && v[8*nb-1]) v = v | ~m;
            end
            r.data = v;
        end else if (instr[6:0] == 7'h23) begin
            if (instr[14]) begin
                r.wben = 1'b0;
                return r;
            end
            if (off % nb != 0) begin
                r.data = 0; r.wben = 1'b0; r.mis = 1'b1;
                return r;
            end
            r.data = 0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn && wb_valid_o) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_wb: got wb_valid_o=1 expected 0");
            end else begin
                wb_t e;
                e = expq.pop_front();
                chk("wb_pc", wb_pc_o, e.pc);
                chk("wb_instr", 64'(wb_instr_o), 64'(e.instr));
                chk("wb_data", wb_data_o, e.data);
                chk("wb_wben", 64'(wb_wben_o), 64'(e.wben));
                chk("misalign", 64'(misalign_o), 64'(e.mis));
            end
        end
    end

    task automatic drive(input logic [63:0] pc, input logic [31:0] instr,
                         input logic [63:0] addr, input logic [63:0] rs2,
                         input logic wben);
        in_valid_i = 1'b1;
        pc_i = pc; instr_i = instr; alures_i = addr;
        rs2_i = rs2; wben_i = wben;
    endtask

    task automatic mem_op(input logic [63:0] pc, input logic [31:0] instr,
                          input logic [63:0] addr, input logic [63:0] rs2,
                          input logic wben, input int stall,
                          input logic [63:0] rdata,
                          output logic [63:0] obs_addr,
                          output logic [63:0] obs_wdata,
                          output logic [7:0] obs_wmask);
        logic [63:0] a8;
        int nb, off;
        expq.push_back(model(pc, instr, addr, wben, rdata));
        drive(pc, instr, addr, rs2, wben);
        @(negedge clk);
        in_valid_i = 1'b0;
        pc_i = '1; alures_i = '1; rs2_i = '1;
        a8  = addr & ~64'h7;
        nb  = 1 << instr[13:12];
        off = int'(addr[2:0]);
        obs_addr = mem_addr_o; obs_wdata = mem_wdata_o;
        obs_wmask = mem_wmask_o;
        chk("req_valid", 64'(mem_req_valid_o), 64'd1);
        chk("req_addr", mem_addr_o, a8);
        chk("ready_busy", 64'(in_ready_o), 64'd0);
        if (instr[6:0] == 7'h23) begin
            chk("req_wen", 64'(mem_wen_o), 64'd1);
            chk("req_wdata", mem_wdata_o, rs2 << (8 * off));
            chk("req_wmask", 64'(mem_wmask_o),
                64'((((1 << nb) - 1) << off) & 8'hFF));
        end else begin
            chk("req_wen", 64'(mem_wen_o), 64'd0);
            chk("req_wmask", 64'(mem_wmask_o), 64'd0);
        end
        for (int i = 0; i < stall; i++) begin
            mem_rsp_valid_i = (i == 1);
            mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            chk("hold_valid", 64'(mem_req_valid_o), 64'd1);
            chk("hold_addr", mem_addr_o, a8);
            chk("hold_ready", 64'(in_ready_o), 64'd0);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        chk("wait_no_req", 64'(mem_req_valid_o), 64'd0);
        chk("wait_ready", 64'(in_ready_o), 64'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = rdata;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        chk("wb_latency", 64'(wb_valid_o), 64'd1);
        chk("idle_ready", 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] oa, od;
        logic [7:0]  om;
        rstn = 1'b0;
        in_valid_i = 1'b0; pc_i = 0; instr_i = 0; alures_i = 0;
        rs2_i = 0; wben_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 0;
        #1;
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_req", 64'(mem_req_valid_o), 64'd0);
        chk("rst_addr", mem_addr_o, 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Back-to-back pass-through, one per cycle.
        for (int i = 0; i < 3; i++) begin
            expq.push_back(model(64'h100 + 64'(4 * i), mk(7'h33, 3'd0),
                                 64'h1234, 1'b1, 64'd0));
            drive(64'h100 + 64'(4 * i), mk(7'h33, 3'd0), 64'h1234,
                  64'd0, 1'b1);
            @(negedge clk);
            chk("pt_valid", 64'(wb_valid_o), 64'd1);
            chk("pt_data", wb_data_o, 64'h1234);
            chk("pt_ready", 64'(in_ready_o), 64'd1);
        end
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("pt_pulse_end", 64'(wb_valid_o), 64'd0);
        chk("pt_hold_data", wb_data_o, 64'h1234);
        chk("pt_hold_pc", wb_pc_o, 64'h108);

        // LB / LBU from lane 3.
        mem_op(64'h200, mk(7'h03, 3'd0), 64'h8000_0003, 64'd0, 1'b1, 0,
               64'h0000_0000_8000_0000, oa, od, om);
        chk("lb_addr", oa, 64'h8000_0000);
        chk("lb_wmask", 64'(om), 64'd0);
        chk("lb_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(64'h204, mk(7'h03, 3'd4), 64'h8000_0003, 64'd0, 1'b1, 0,
               64'h0000_0000_8000_0000, oa, od, om);
        chk("lbu_data", wb_data_o, 64'h80);

        // SH into lanes 6-7.
        mem_op(64'h208, mk(7'h23, 3'd1), 64'h8000_0006, 64'hABCD_1234,
               1'b0, 0, 64'd0, oa, od, om);
        chk("sh_wmask", 64'(om), 64'hC0);
        chk("sh_wdata", od, 64'h1234_0000_0000_0000);
        chk("sh_wb_data", wb_data_o, 64'd0);

        // LD under backpressure, with a stray response during REQ.
        mem_op(64'h20C, mk(7'h03, 3'd3), 64'h8000_0008, 64'd0, 1'b1, 3,
               64'h1122_3344_5566_7788, oa, od, om);
        chk("ld_data", wb_data_o, 64'h1122_3344_5566_7788);

        mem_op(64'h210, mk(7'h03, 3'd1), 64'h8000_0002, 64'd0, 1'b1, 0,
               64'h0000_0000_8001_0000, oa, od, om);
        chk("lh_data", wb_data_o, 64'hFFFF_FFFF_FFFF_8001);
        mem_op(64'h214, mk(7'h03, 3'd6), 64'h8000_0004, 64'd0, 1'b1, 1,
               64'hDEAD_BEEF_0000_0000, oa, od, om);
        chk("lwu_data", wb_data_o, 64'h0000_0000_DEAD_BEEF);

        // Misaligned LW.
        expq.push_back(model(64'h218, mk(7'h03, 3'd2), 64'h8000_0002,
                             1'b1, 64'd0));
        drive(64'h218, mk(7'h03, 3'd2), 64'h8000_0002, 64'd0, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("mis_no_req", 64'(mem_req_valid_o), 64'd0);
        chk("mis_valid", 64'(wb_valid_o), 64'd1);
        chk("mis_flag", 64'(misalign_o), 64'd1);
        chk("mis_wben", 64'(wb_wben_o), 64'd0);
        chk("mis_ready", 64'(in_ready_o), 64'd1);

        // Store funct3 1xx falls through with wben cleared.
        expq.push_back(model(64'h21C, mk(7'h23, 3'd4), 64'h55, 1'b1,
                             64'd0));
        drive(64'h21C, mk(7'h23, 3'd4), 64'h55, 64'd0, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("bad_st_data", wb_data_o, 64'h55);
        chk("bad_st_wben", 64'(wb_wben_o), 64'd0);
        chk("bad_st_no_req", 64'(mem_req_valid_o), 64'd0);

        // Reset while waiting for the response.
        drive(64'h220, mk(7'h03, 3'd2), 64'h8000_0010, 64'd0, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        chk("pre_rst_wait", 64'(mem_req_valid_o), 64'd0);
        rstn = 1'b0;
        #1;
        chk("mrst_ready", 64'(in_ready_o), 64'd1);
        chk("mrst_req", 64'(mem_req_valid_o), 64'd0);
        chk("mrst_addr", mem_addr_o, 64'd0);
        chk("mrst_wdata", mem_wdata_o, 64'd0);
        chk("mrst_wmask", 64'(mem_wmask_o), 64'd0);
        chk("mrst_wen", 64'(mem_wen_o), 64'd0);
        chk("mrst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("mrst_wb_data", wb_data_o, 64'd0);
        chk("mrst_wb_pc", wb_pc_o, 64'd0);
        chk("mrst_mis", 64'(misalign_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = 64'h1;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        chk("late_rsp_1", 64'(wb_valid_o), 64'd0);
        @(negedge clk);
        chk("late_rsp_2", 64'(wb_valid_o), 64'd0);

        expq.push_back(model(64'h300, mk(7'h13, 3'd0), 64'h77, 1'b1,
                             64'd0));
        drive(64'h300, mk(7'h13, 3'd0), 64'h77, 64'd0, 1'b1);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("post_rst_pt", wb_data_o, 64'h77);
        @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
